// File: rtl/shifter_pkg.sv
// Shared shifter definitions: operand width, shift-amount width and FSM state type.
// Used by right_shifter_seq, left_lshifter and the ALU result path.
package shifter_pkg;

  localparam int XLEN    = 64;
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int STAGE_W = $clog2(SHAMT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rshift_state_t;

endpackage

// File: rtl/right_shift_stage.sv
// One log2 stage of the right shifter: shifts by 2^stage when en is set,
// filling vacated upper bits with the fill bit.
module right_shift_stage
  import shifter_pkg::*;
(
  input  logic [XLEN-1:0]    data,
  input  logic [STAGE_W-1:0] stage,
  input  logic               en,
  input  logic               fill,
  output logic [XLEN-1:0]    d_out
);

  logic [SHAMT_W:0] w_amt;
  logic [XLEN-1:0]  w_logical;
  logic [XLEN-1:0]  w_fill_mask;

  assign w_amt       = (SHAMT_W + 1)'(1) << stage;
  assign w_logical   = data >> w_amt;
  // Ones exactly in the bit positions vacated by the shift.
  assign w_fill_mask = ~({XLEN{1'b1}} >> w_amt);

  always_comb begin
    d_out = data;
    if (en) begin
      d_out = fill ? (w_logical | w_fill_mask) : w_logical;
    end
  end

endmodule

// File: rtl/right_shifter_seq.sv
// Multi-cycle 64-bit right shifter (logical/arithmetic), one log2 stage per clock,
// valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid; operands latched on accept
// SHIFT | applying stages SHAMT_W-1 down to 0, one per edge
// DONE  | out_valid=1, s held until out_ready
module right_shifter_seq
  import shifter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            arith,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] s,
  output logic            busy
);

  rshift_state_t      r_state;
  logic [XLEN-1:0]    r_data;
  logic [SHAMT_W-1:0] r_shamt;
  logic [STAGE_W-1:0] r_stage;
  logic               r_fill;
  logic [XLEN-1:0]    r_s;
  logic               r_out_valid;
  logic               r_in_ready;
  logic               r_busy;

  logic [XLEN-1:0]    w_next_data;
  logic               w_stage_en;
  logic               w_unused_b_hi;

  // Only the low SHAMT_W bits of b select the shift; the rest is don't-care.
  assign w_unused_b_hi = ^b[XLEN-1:SHAMT_W];

  assign w_stage_en = r_shamt[r_stage];

  right_shift_stage u_stage (
    .data  (r_data),
    .stage (r_stage),
    .en    (w_stage_en),
    .fill  (r_fill),
    .d_out (w_next_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_shamt     <= '0;
      r_stage     <= '0;
      r_fill      <= 1'b0;
      r_s         <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data     <= a;
            r_shamt    <= b[SHAMT_W-1:0];
            r_fill     <= arith & a[XLEN-1];
            r_stage    <= STAGE_W'(SHAMT_W - 1);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_data <= w_next_data;
          if (r_stage == '0) begin
            r_s         <= w_next_data;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_stage <= r_stage - STAGE_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign busy      = r_busy;

endmodule

// File: tb/tb_right_shifter_seq.sv
// Directed self-checking bench for right_shifter_seq: shift amounts, sign fill,
// latency/back-pressure, operand isolation and async reset abort.
module tb_right_shifter_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] s;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int accepts = 0;

  right_shifter_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) accepts++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for the result, then take it.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tar,
                        output logic [63:0] res);
    int n;
    @(negedge clk);
    a = ta; b = tb_; arith = tar; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("op_timeout", {63'd0, out_valid}, 64'd1);
    res = s;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    int acc0;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; arith = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s", s, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;

    // 1: single one bit walked right by every amount
    for (int i = 0; i < 64; i++) begin
      run_op(64'h1, 64'(i), 1'b0, res);
      chk($sformatf("walk_%0d", i), res, (i == 0) ? 64'h1 : 64'h0);
    end

    // 2: sign bit shifted by 63, arithmetic and logical
    run_op(64'h8000_0000_0000_0000, 64'd63, 1'b1, res);
    chk("sra63", res, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'h8000_0000_0000_0000, 64'd63, 1'b0, res);
    chk("srl63", res, 64'h1);

    // 3: upper bits of b ignored
    run_op(64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_FFFF_FF44, 1'b0, res);
    chk("b_upper_ignored", res, 64'h0DEA_DBEE_F000_0000);
    run_op(64'hF000_0000_0000_0001, 64'd1, 1'b1, res);
    chk("sra1_neg", res, 64'hF800_0000_0000_0000);
    run_op(64'h7000_0000_0000_0000, 64'd60, 1'b1, res);
    chk("sra60_pos", res, 64'h7);

    // 4: fixed latency and back-pressure
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'd8; arith = 1'b0; in_valid = 1'b1;
    @(negedge clk);   // E0 has passed
    in_valid = 1'b0;
    chk("lat_busy_e0", {63'd0, busy}, 64'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("lat_no_valid_e%0d", k), {63'd0, out_valid}, 64'd0);
      chk($sformatf("lat_in_ready_e%0d", k), {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);   // after E0+6
    chk("lat_valid_e6", {63'd0, out_valid}, 64'd1);
    chk("lat_result", s, 64'h0012_3456_789A_BCDE);
    held = s;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp_stable_%0d", k), s, 64'h0012_3456_789A_BCDE);
      chk($sformatf("bp_in_ready_%0d", k), {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_release_busy", {63'd0, busy}, 64'd0);
    chk("bp_s_held", s, held);

    // 5: operand churn while busy, in_valid kept high
    acc0 = accepts;
    @(negedge clk);
    a = 64'hFFFF_0000_0000_0000; b = 64'd16; arith = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8 && !out_valid; k++) begin
      @(negedge clk);
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; arith = ~arith;
    end
    in_valid = 1'b0;
    chk("churn_valid", {63'd0, out_valid}, 64'd1);
    chk("churn_result", s, 64'hFFFF_FFFF_0000_0000);
    chk("churn_accepts", 64'(accepts - acc0), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // 6: async reset mid-SHIFT
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd3; arith = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_s", s, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'hF0, 64'd4, 1'b0, res);
    chk("post_rst_op", res, 64'hF);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
